// File: rtl/retire_trace_unit.sv
// Retirement monitor: packs writeback retire events into trace records, buffers them in a
// show-ahead FIFO and tracks counters, halt and a watchdog. Define RETIRE_TRACE_NOP_FILTER_EN for nop filtering.
module retire_trace_unit #(
   parameter  int ADDR_W  = 16,
   parameter  int DATA_W  = 16,
   parameter  int DEPTH   = 16,
   parameter  int CNT_W   = 32,
   parameter  int TIMEOUT = 100000,
   localparam int REC_W   = 3 + 4 + 2*ADDR_W + DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ret_valid,
   input  logic [ADDR_W-1:0] ret_pc,
   input  logic              ret_reg_wr,
   input  logic [3:0]        ret_reg,
   input  logic [DATA_W-1:0] ret_wdata,
   input  logic              ret_mem_rd,
   input  logic              ret_mem_wr,
   input  logic [ADDR_W-1:0] ret_mem_addr,
   input  logic [DATA_W-1:0] ret_mem_data,
   input  logic              ret_halt,
`ifdef RETIRE_TRACE_NOP_FILTER_EN
   input  logic              filter_nop,
`endif
   output logic              tr_valid,
   input  logic              tr_ready,
   output logic [REC_W-1:0]  tr_data,
   output logic [CNT_W-1:0]  inst_count,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic              halted,
   output logic              timeout
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W+1)'(1);
   localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_TIMEOUT} stateT;
   typedef enum logic [1:0] {KIND_NOP = 2'd0, KIND_REG = 2'd1, KIND_STORE = 2'd2, KIND_HALT = 2'd3} kindT;

   stateT               state;
   kindT                kind;
   logic                recLd;
   logic [3:0]          recReg;
   logic [DATA_W-1:0]   recValue;
   logic [ADDR_W-1:0]   recAddr;
   logic [REC_W-1:0]    record;
   logic [IDLE_W-1:0]   idleCount;

   logic [REC_W-1:0]    fifoMem [DEPTH];
   logic [PTR_W:0]      wrPtr;
   logic [PTR_W:0]      rdPtr;
   logic                fifoEmpty;
   logic                fifoFull;
   logic                accept;
   logic                filtered;
   logic                pop;
   logic                push;
   logic                drop;

   // Record packing: halt outranks register write, which outranks store.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the block infers a latch.
      kind     = KIND_NOP;
      recLd    = 1'b0;
      recReg   = '0;
      recValue = '0;
      recAddr  = '0;
      if (ret_halt)
         kind = KIND_HALT;
      else if (ret_reg_wr)
         kind = KIND_REG;
      else if (ret_mem_wr)
         kind = KIND_STORE;

      if (kind == KIND_REG) begin
         recReg   = ret_reg;
         recValue = ret_wdata;
         recLd    = ret_mem_rd;
      end else if (kind == KIND_STORE) begin
         recValue = ret_mem_data;
      end

      if (recLd || kind == KIND_STORE)
         recAddr = ret_mem_addr;
   end

   assign record = {kind, recLd, recReg, ret_pc, recValue, recAddr};

`ifdef RETIRE_TRACE_NOP_FILTER_EN
   assign filtered = filter_nop && (kind == KIND_NOP);
`else
   assign filtered = 1'b0;
`endif

   assign accept    = ret_valid && (state == ST_RUN);
   assign fifoEmpty = (wrPtr == rdPtr);
   assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
   assign pop       = !fifoEmpty && tr_ready;
   // A full FIFO still takes the new record when the head leaves on the same edge.
   assign push      = accept && !filtered && (!fifoFull || pop);
   assign drop      = accept && !filtered && fifoFull && !pop;

   assign tr_valid  = !fifoEmpty;
   assign tr_data   = fifoEmpty ? '0 : fifoMem[rdPtr[PTR_W-1:0]];

   // NOTE: the storage array has no reset; only the pointers define what is valid, so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (push)
         fifoMem[wrPtr[PTR_W-1:0]] <= record;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push)
            wrPtr <= wrPtr + PTR_ONE;
         if (pop)
            rdPtr <= rdPtr + PTR_ONE;
      end
   end

   // Control FSM, counters and sticky status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         idleCount   <= '0;
         inst_count  <= '0;
         cycle_count <= '0;
         drop_count  <= '0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         if (accept && inst_count != CNT_MAX)
            inst_count <= inst_count + CNT_ONE;
         if (drop && drop_count != CNT_MAX)
            drop_count <= drop_count + CNT_ONE;

         case (state)
            ST_RUN: begin
               if (cycle_count != CNT_MAX)
                  cycle_count <= cycle_count + CNT_ONE;
               if (ret_valid) begin
                  idleCount <= '0;
                  if (ret_halt) begin
                     state  <= ST_HALTED;
                     halted <= 1'b1;
                  end
               end else if (idleCount == IDLE_LAST) begin
                  state   <= ST_TIMEOUT;
                  timeout <= 1'b1;
               end else begin
                  idleCount <= idleCount + IDLE_ONE;
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_retire_trace_unit.sv
// Self-checking bench for retire_trace_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_retire_trace_unit;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int DEPTH   = 16;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 8;
   localparam int REC_W   = 3 + 4 + 2*ADDR_W + DATA_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef logic [REC_W-1:0] recT;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              ret_valid = 1'b0;
   logic [ADDR_W-1:0] ret_pc = '0;
   logic              ret_reg_wr = 1'b0;
   logic [3:0]        ret_reg = '0;
   logic [DATA_W-1:0] ret_wdata = '0;
   logic              ret_mem_rd = 1'b0;
   logic              ret_mem_wr = 1'b0;
   logic [ADDR_W-1:0] ret_mem_addr = '0;
   logic [DATA_W-1:0] ret_mem_data = '0;
   logic              ret_halt = 1'b0;
   logic              tr_valid;
   logic              tr_ready = 1'b0;
   recT               tr_data;
   logic [CNT_W-1:0]  inst_count;
   logic [CNT_W-1:0]  cycle_count;
   logic [CNT_W-1:0]  drop_count;
   logic              halted;
   logic              timeout;

   int nChecks = 0;
   int nFail   = 0;

   // Reference model state
   recT mq[$];
   int  mInst, mCycle, mDrop, mIdle;
   bit  mHalted, mTimeout;

   retire_trace_unit #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_reg_wr(ret_reg_wr), .ret_reg(ret_reg),
      .ret_wdata(ret_wdata), .ret_mem_rd(ret_mem_rd), .ret_mem_wr(ret_mem_wr),
      .ret_mem_addr(ret_mem_addr), .ret_mem_data(ret_mem_data), .ret_halt(ret_halt),
      .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
      .inst_count(inst_count), .cycle_count(cycle_count), .drop_count(drop_count),
      .halted(halted), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   // Record built directly from the field rules.
   function automatic recT expRecord();
      logic [1:0]        k;
      logic              ld;
      logic [3:0]        r;
      logic [DATA_W-1:0] v;
      logic [ADDR_W-1:0] a;
      if (ret_halt)        k = 2'd3;
      else if (ret_reg_wr) k = 2'd1;
      else if (ret_mem_wr) k = 2'd2;
      else                 k = 2'd0;
      ld = ret_mem_rd && (k == 2'd1);
      r  = (k == 2'd1) ? ret_reg : 4'd0;
      if (k == 2'd1)      v = ret_wdata;
      else if (k == 2'd2) v = ret_mem_data;
      else                v = '0;
      a  = (ld || k == 2'd2) ? ret_mem_addr : '0;
      return {k, ld, r, ret_pc, v, a};
   endfunction

   task automatic modelClear();
      mq.delete();
      mInst = 0; mCycle = 0; mDrop = 0; mIdle = 0;
      mHalted = 1'b0; mTimeout = 1'b0;
   endtask

   task automatic compareAll(input string tag);
      recT head;
      head = (mq.size() > 0) ? mq[0] : '0;
      check({tag, ".tr_valid"}, 64'(tr_valid), 64'(mq.size() > 0));
      check({tag, ".tr_data"},  64'(tr_data),  64'(head));
      check({tag, ".inst"},     64'(inst_count),  64'(mInst));
      check({tag, ".cycle"},    64'(cycle_count), 64'(mCycle));
      check({tag, ".drop"},     64'(drop_count),  64'(mDrop));
      check({tag, ".halted"},   64'(halted),  64'(mHalted));
      check({tag, ".timeout"},  64'(timeout), 64'(mTimeout));
   endtask

   // Advance model and DUT by one clock using the inputs currently driven.
   task automatic step(input string tag);
      bit  run, acc, doPop;
      int  sizeBefore;
      recT rec, gone;
      run        = !mHalted && !mTimeout;
      acc        = run && ret_valid;
      doPop      = (mq.size() > 0) && tr_ready;
      sizeBefore = mq.size();
      rec        = expRecord();
      if (doPop) gone = mq.pop_front();
      if (acc) begin
         if (sizeBefore < DEPTH || doPop) mq.push_back(rec);
         else mDrop = sat(mDrop + 1);
         mInst = sat(mInst + 1);
      end
      if (run) begin
         mCycle = sat(mCycle + 1);
         if (ret_valid) begin
            mIdle = 0;
            if (ret_halt) mHalted = 1'b1;
         end else begin
            mIdle++;
            if (mIdle == TIMEOUT) mTimeout = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      compareAll(tag);
   endtask

   task automatic setIdle();
      ret_valid = 1'b0; ret_pc = '0; ret_reg_wr = 1'b0; ret_reg = '0; ret_wdata = '0;
      ret_mem_rd = 1'b0; ret_mem_wr = 1'b0; ret_mem_addr = '0; ret_mem_data = '0; ret_halt = 1'b0;
   endtask

   task automatic setNop(input logic [ADDR_W-1:0] pc);
      setIdle();
      ret_valid = 1'b1;
      ret_pc    = pc;
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
   task automatic doReset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, ".rst_tr_valid"}, 64'(tr_valid), 64'd0);
      check({tag, ".rst_tr_data"},  64'(tr_data), 64'd0);
      check({tag, ".rst_inst"},     64'(inst_count), 64'd0);
      check({tag, ".rst_cycle"},    64'(cycle_count), 64'd0);
      check({tag, ".rst_drop"},     64'(drop_count), 64'd0);
      check({tag, ".rst_flags"},    64'({halted, timeout}), 64'd0);
      modelClear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic randEvent(input int validPct, input int haltPct, input int readyPct);
      ret_valid    = ($urandom_range(99) < validPct);
      ret_pc       = ADDR_W'($urandom);
      ret_reg_wr   = 1'($urandom);
      ret_reg      = 4'($urandom);
      ret_wdata    = DATA_W'($urandom);
      ret_mem_rd   = 1'($urandom);
      ret_mem_wr   = 1'($urandom);
      ret_mem_addr = ADDR_W'($urandom);
      ret_mem_data = DATA_W'($urandom);
      ret_halt     = ($urandom_range(99) < haltPct);
      tr_ready     = ($urandom_range(99) < readyPct);
   endtask

   initial begin
      recT exp;
      int  pops;
      modelClear();
      #3;
      doReset("init");

      // Register write
      setIdle();
      tr_ready = 1'b1;
      ret_valid = 1'b1; ret_reg_wr = 1'b1; ret_reg = 4'd5; ret_wdata = 16'h1234; ret_pc = 16'h0010;
      step("regwr");
      exp = {2'd1, 1'b0, 4'd5, 16'h0010, 16'h1234, 16'h0000};
      check("regwr_record", 64'(tr_data), 64'(exp));
      check("regwr_inst", 64'(inst_count), 64'd1);

      // Load then store on consecutive cycles
      setIdle();
      ret_valid = 1'b1; ret_reg_wr = 1'b1; ret_reg = 4'd2; ret_mem_rd = 1'b1;
      ret_mem_addr = 16'h0040; ret_wdata = 16'h00AA; ret_pc = 16'h0011;
      step("load");
      exp = {2'd1, 1'b1, 4'd2, 16'h0011, 16'h00AA, 16'h0040};
      check("load_record", 64'(tr_data), 64'(exp));
      setIdle();
      ret_valid = 1'b1; ret_mem_wr = 1'b1; ret_mem_addr = 16'h0042; ret_mem_data = 16'hBEEF;
      ret_reg = 4'd9; ret_pc = 16'h0012;
      step("store");
      exp = {2'd2, 1'b0, 4'd0, 16'h0012, 16'hBEEF, 16'h0042};
      check("store_record", 64'(tr_data), 64'(exp));

      // Overflow: 20 nops into a stalled FIFO, then drain in order
      doReset("ovf");
      tr_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         setNop(16'h0100 + 16'(i));
         step("ovf_fill");
      end
      check("ovf_drop", 64'(drop_count), 64'd4);
      check("ovf_inst", 64'(inst_count), 64'd20);
      setIdle();
      tr_ready = 1'b1;
      pops = 0;
      for (int i = 0; i < 20; i++) begin
         if (tr_valid) begin
            check("ovf_order", 64'(tr_data[47:32]), 64'(16'h0100 + 16'(pops)));
            pops++;
         end
         step("ovf_drain");
      end
      check("ovf_pops", 64'(pops), 64'd16);

      // Full FIFO with a simultaneous pop accepts the new record
      doReset("fullpop");
      tr_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         setNop(16'h0100 + 16'(i));
         step("fullpop_fill");
      end
      setNop(16'h0200);
      tr_ready = 1'b1;
      step("fullpop_push");
      check("fullpop_drop", 64'(drop_count), 64'd0);
      check("fullpop_inst", 64'(inst_count), 64'(DEPTH + 1));

      // Halt beats register write; later events are ignored
      doReset("halt");
      setIdle();
      tr_ready = 1'b0;
      ret_valid = 1'b1; ret_halt = 1'b1; ret_reg_wr = 1'b1; ret_reg = 4'd7; ret_pc = 16'h0300;
      step("halt");
      check("halt_kind", 64'(tr_data[REC_W-1 -: 2]), 64'd3);
      check("halt_flag", 64'(halted), 64'd1);
      for (int i = 0; i < 6; i++) begin
         setNop(16'h0301 + 16'(i));
         step("halt_frozen");
      end
      check("halt_inst_frozen", 64'(inst_count), 64'd1);
      check("halt_cycle_frozen", 64'(cycle_count), 64'd1);
      check("halt_no_timeout", 64'(timeout), 64'd0);

      // Watchdog with no retirement after reset
      doReset("wdog");
      setIdle();
      tr_ready = 1'b0;
      for (int i = 0; i < TIMEOUT - 1; i++) step("wdog_idle");
      check("wdog_not_yet", 64'(timeout), 64'd0);
      step("wdog_fire");
      check("wdog_timeout", 64'(timeout), 64'd1);
      check("wdog_cycle", 64'(cycle_count), 64'(TIMEOUT));
      check("wdog_not_halted", 64'(halted), 64'd0);
      setNop(16'h0400);
      step("wdog_ignored");
      check("wdog_inst", 64'(inst_count), 64'd0);

      // Randomized traffic: dense (saturation), halting, sparse (watchdog), bursty
      for (int run = 0; run < 4; run++) begin
         int vp, hp, rp;
         case (run)
            0: begin vp = 95; hp = 0; rp = 60; end
            1: begin vp = 85; hp = 2; rp = 50; end
            2: begin vp = 45; hp = 0; rp = 70; end
            default: begin vp = 90; hp = 0; rp = 15; end
         endcase
         doReset("rand");
         for (int c = 0; c < 300; c++) begin
            randEvent(vp, hp, rp);
            step("rand");
         end
      end
      doReset("final");

      $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/retire_trace_unit.md
Name: retire_trace_unit

Overview:
- Synthesizable retirement monitor for the pipelined cpu.
- Each cycle it samples at most one retire event from writeback: register write, load, store, nop/branch or halt.
- It packs the event into a fixed trace record and buffers records in a FIFO that a trace drain or debug port reads.
- It keeps instruction and cycle counters, detects halt, and raises a watchdog timeout when retirement stops.

Parameters:
- ADDR_W, 16, PC and memory-address width.
- DATA_W, 16, register/memory data width.
- DEPTH, 16, trace FIFO entries; power of 2, minimum 2.
- CNT_W, 32, width of the instruction, cycle and drop counters.
- TIMEOUT, 100000, number of consecutive cycles with no retire before the timeout flag is raised.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ret_valid  in  1  a retire event is present this cycle.
- ret_pc  in  ADDR_W  PC of the retiring instruction.
- ret_reg_wr  in  1  register-file write.
- ret_reg  in  4  destination register.
- ret_wdata  in  DATA_W  register write data.
- ret_mem_rd  in  1  instruction is a load.
- ret_mem_wr  in  1  instruction is a store.
- ret_mem_addr  in  ADDR_W  memory address.
- ret_mem_data  in  DATA_W  store data.
- ret_halt  in  1  halt retiring.
- tr_valid  out  1  FIFO head is valid.
- tr_ready  in  1  consumer accepts the head record.
- tr_data  out  REC_W  head record; REC_W = 3+4+2*ADDR_W+DATA_W.
- inst_count  out  CNT_W  retired instructions.
- cycle_count  out  CNT_W  cycles spent in RUN.
- drop_count  out  CNT_W  records lost because the FIFO was full.
- halted  out  1  sticky; halt has retired.
- timeout  out  1  sticky; watchdog has expired.

Behaviour:
- Reset: all outputs 0, FIFO empty, state RUN. Reset is asynchronous and takes effect mid-operation: FIFO contents are discarded and the counters cleared.
- States:
  - RUN: accept retire events, count cycles.
  - HALTED: entered on an accepted ret_halt.
  - TIMEOUT: entered when the idle counter reaches TIMEOUT.
  - HALTED and TIMEOUT are terminal until reset. In both, ret_valid is ignored, cycle_count freezes and the FIFO still drains.
- Kind encoding and priority, in this order when ret_valid=1:
  - halt: 3
  - ret_reg_wr: 1
  - ret_mem_wr: 2
  - otherwise nop/branch: 0
- Record layout, MSB to LSB: kind[1:0], ld, reg[3:0], pc, value, addr.
  - ld = ret_mem_rd & (kind==1).
  - value = ret_wdata for kind 1, ret_mem_data for kind 2, else 0.
  - addr = ret_mem_addr when ld or kind 2, else 0.
  - reg = ret_reg for kind 1, else 0.
- Latency: an event sampled at edge N is visible on tr_valid/tr_data after edge N. The FIFO is show-ahead.
- FIFO:
  - Pop on tr_valid&tr_ready.
  - Push when the event is accepted and the FIFO is not full, or when it is full and a pop happens the same cycle.
  - Otherwise the record is dropped and drop_count increments.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally. tr_valid = not empty.
- inst_count increments on every accepted ret_valid in RUN, including dropped records and the halt.
- cycle_count increments every cycle in RUN, including the cycle the halt is accepted.
- All counters saturate at all-ones; they never wrap.
- Watchdog:
  - The idle counter clears on any ret_valid and increments otherwise in RUN.
  - When it equals TIMEOUT-1 and ret_valid=0, timeout is set and the state moves to TIMEOUT.
  - If ret_halt is present on that same cycle, the halt wins.
- halted and timeout are never both 1.

Optional Feature:
- Macro RETIRE_TRACE_NOP_FILTER_EN.
- When defined:
  - Adds input port filter_nop (1 bit).
  - While filter_nop=1, kind-0 events are not pushed and do not count as drops.
  - They still increment inst_count and still clear the watchdog.
- When undefined: the port is absent and every accepted event is pushed.

Test Plan:
- Reg write: ret_valid=1, ret_reg_wr=1, reg=5, wdata=0x1234, pc=0x0010, tr_ready=1.
  - Next cycle: tr_valid=1, kind=1, ld=0, reg=5, value=0x1234, addr=0; inst_count=1.
- Load then store, consecutive cycles:
  - Load (reg 2, mem_rd, addr 0x0040) -> record with ld=1, addr=0x0040.
  - Store (addr 0x0042, data 0xBEEF) -> kind=2, reg=0, value=0xBEEF.
- Overflow: tr_ready=0, DEPTH=16, 20 back-to-back nops.
  - 16 records held, drop_count=4, inst_count=20.
  - Then tr_ready=1: exactly 16 pops in PC order.
- Full with simultaneous pop: FIFO full, tr_ready=1, new event on the same cycle -> pushed, no drop.
- Halt beats reg write: ret_halt=1 with ret_reg_wr=1 -> record kind=3.
  - halted=1 next cycle.
  - Later ret_valid ignored; inst_count and cycle_count frozen.
- Watchdog: TIMEOUT=8, no ret_valid after reset -> timeout=1 after the 8th cycle, cycle_count=8.
  - Assert rst_n=0 mid-run: all outputs 0 immediately.
